// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low row drive, debounced press/release,
// hex decode and a 4-digit shift buffer suitable for a seven-segment display.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned DEB_TICKS = 20
) (
   input  logic        clk,
   input  logic        rst,
   output logic [3:0]  rows,
   input  logic [3:0]  cols,
   input  logic        clr,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [15:0] digits
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DEB_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
      endcase
   endfunction

   // Lowest-index active column wins when several keys share a row
   function automatic logic [1:0] low_col(input logic [3:0] p);
      if (!p[0])      low_col = 2'd0;
      else if (!p[1]) low_col = 2'd1;
      else if (!p[2]) low_col = 2'd2;
      else            low_col = 2'd3;
   endfunction

   state_t            state, state_d;
   logic [3:0]        cols_m, cols_s;
   logic [DIV_W-1:0]  div_cnt;
   logic              scan_tick;
   logic [1:0]        row_idx, row_idx_d, key_row, key_row_d, key_col, key_col_d;
   logic [3:0]        rows_d, pattern, pattern_d, code_c;
   logic [DEB_W-1:0]  deb_cnt, deb_cnt_d, rel_cnt, rel_cnt_d;
   logic              accept_c;

   assign scan_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

   // Next-state and datapath decisions; everything is sampled only on scan_tick
   always_comb begin
      state_d   = state;
      rows_d    = rows;
      row_idx_d = row_idx;
      key_row_d = key_row;
      key_col_d = key_col;
      pattern_d = pattern;
      deb_cnt_d = deb_cnt;
      rel_cnt_d = rel_cnt;
      accept_c  = 1'b0;
      code_c    = key_map(key_row, key_col);
      case (state)
         SCAN: if (scan_tick) begin
            if (cols_s == 4'hF) begin
               rows_d    = {rows[2:0], rows[3]};
               row_idx_d = row_idx + 2'd1;
            end else begin
               key_row_d = row_idx;
               key_col_d = low_col(cols_s);
               pattern_d = cols_s;
               deb_cnt_d = DEB_W'(1);
               code_c    = key_map(row_idx, low_col(cols_s));
               if (DEB_TICKS <= 1) begin
                  accept_c  = 1'b1;
                  deb_cnt_d = '0;
                  rel_cnt_d = '0;
                  state_d   = HELD;
               end else begin
                  state_d = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: if (scan_tick) begin
            if (cols_s == pattern) begin
               if (deb_cnt == DEB_W'(DEB_TICKS - 1)) begin
                  accept_c  = 1'b1;
                  deb_cnt_d = '0;
                  rel_cnt_d = '0;
                  state_d   = HELD;
               end else begin
                  deb_cnt_d = deb_cnt + DEB_W'(1);
               end
            end else begin
               deb_cnt_d = '0;
               rows_d    = {rows[2:0], rows[3]};
               row_idx_d = row_idx + 2'd1;
               state_d   = SCAN;
            end
         end
         HELD: if (scan_tick) begin
            if (cols_s == 4'hF) begin
               if (rel_cnt == DEB_W'(DEB_TICKS - 1)) begin
                  rel_cnt_d = '0;
                  rows_d    = {rows[2:0], rows[3]};
                  row_idx_d = row_idx + 2'd1;
                  state_d   = SCAN;
               end else begin
                  rel_cnt_d = rel_cnt + DEB_W'(1);
               end
            end else begin
               rel_cnt_d = '0;
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         cols_m    <= 4'hF;
         cols_s    <= 4'hF;
         div_cnt   <= '0;
         rows      <= 4'b1110;
         row_idx   <= 2'd0;
         key_row   <= 2'd0;
         key_col   <= 2'd0;
         pattern   <= 4'hF;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         key_held  <= 1'b0;
         digits    <= 16'h0;
      end else begin
         state     <= state_d;
         cols_m    <= cols;
         cols_s    <= cols_m;
         div_cnt   <= scan_tick ? '0 : div_cnt + DIV_W'(1);
         rows      <= rows_d;
         row_idx   <= row_idx_d;
         key_row   <= key_row_d;
         key_col   <= key_col_d;
         pattern   <= pattern_d;
         deb_cnt   <= deb_cnt_d;
         rel_cnt   <= rel_cnt_d;
         key_valid <= accept_c;
         key_held  <= (state_d == HELD);
         if (accept_c) key_code <= code_c;
         // Clear has priority over a coincident key shift
         if (clr)           digits <= 16'h0;
         else if (accept_c) digits <= {digits[11:0], code_c};
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives cols from rows and the
// set of pressed keys; a negedge monitor checks every key_valid pulse against the queue.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic [3:0]  rows, cols;
   logic        key_valid, key_held;
   logic [3:0]  key_code;
   logic [15:0] digits;

   logic [15:0] pressed = 16'h0;
   logic [15:0] exp_digits = 16'h0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_pulse = 0;
   logic        prev_valid = 1'b0;

   typedef struct packed {
      logic [3:0]  code;
      logic [15:0] digits;
   } exp_t;
   exp_t sb_q[$];

   keypad_scanner #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
      .clk(clk), .rst(rst), .rows(rows), .cols(cols), .clr(clr),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .digits(digits)
   );

   always #5 clk = ~clk;

   // Passive matrix: a pressed key pulls its column low while its row is driven low
   always_comb begin
      cols = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*r+c] && !rows[r]) cols[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && key_valid) begin
         n_pulse++;
         check("pulse_width", prev_valid, 1'b0);
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("key_code", key_code, e.code);
            check("digits", digits, e.digits);
         end
      end
      prev_valid = key_valid & !rst;
   end

   task automatic wait_held(input logic v);
      int t = 0;
      while (key_held !== v && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("wait_held", key_held, v);
   endtask

   // Returns on the negedge right after rows rotates onto target
   task automatic wait_row(input logic [3:0] target);
      int t = 0;
      while (rows == target && t < 100) begin @(negedge clk); t++; end
      while (rows != target && t < 100) begin @(negedge clk); t++; end
      check("wait_row", rows, target);
   endtask

   task automatic expect_key(input logic [3:0] code);
      exp_digits = {exp_digits[11:0], code};
      sb_q.push_back({code, exp_digits});
   endtask

   task automatic press(input int r, input int c, input logic [3:0] code);
      expect_key(code);
      pressed[4*r+c] = 1'b1;
      wait_held(1'b1);
      repeat (8) @(negedge clk);
      pressed[4*r+c] = 1'b0;
      wait_held(1'b0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] walk [5];
      walk[0] = 4'b1110; walk[1] = 4'b1101; walk[2] = 4'b1011; walk[3] = 4'b0111; walk[4] = 4'b1110;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rows", rows, 4'b1110);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 4'h0);
      check("rst_held", key_held, 1'b0);
      check("rst_digits", digits, 16'h0);
      rst = 1'b0;

      // Idle row walk: one rotation every 4 clocks
      for (int i = 1; i < 5; i++) begin
         repeat (4) @(posedge clk);
         @(negedge clk);
         check("row_walk", rows, walk[i]);
      end

      // Key "2" (r0c1): accepted, held with rows frozen, release resumes scanning
      expect_key(4'h2);
      pressed[1] = 1'b1;
      wait_held(1'b1);
      check("held_rows", rows, 4'b1110);
      check("held_digits", digits, 16'h0002);
      repeat (12) @(negedge clk);
      check("frozen_rows", rows, 4'b1110);
      check("still_held", key_held, 1'b1);
      pressed[1] = 1'b0;
      wait_held(1'b0);
      check("release_rotate", rows, 4'b1101);
      repeat (2) @(negedge clk);

      press(1, 1, 4'h5);
      press(0, 3, 4'hA);
      press(3, 1, 4'h0);
      press(3, 3, 4'hD);
      check("digits_5A0D", digits, 16'h5A0D);

      // Bounce on r1c2: two matching samples, then released before the third
      wait_row(4'b1101);
      pressed[6] = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      pressed[6] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("bounce_rows", rows, 4'b1011);
      check("bounce_held", key_held, 1'b0);
      repeat (8) @(negedge clk);

      // Two keys on r2 decode to the lower column; a r3 key while held is ignored
      expect_key(4'h7);
      pressed[8] = 1'b1;
      pressed[9] = 1'b1;
      wait_held(1'b1);
      pressed[13] = 1'b1;
      repeat (16) @(negedge clk);
      check("multi_held", key_held, 1'b1);
      check("multi_rows", rows, 4'b1011);
      pressed = 16'h0;
      wait_held(1'b0);
      repeat (2) @(negedge clk);

      // clr coincident with accept of "3" (r0c2): pulse and code survive, digits cleared
      wait_row(4'b1110);
      exp_digits = 16'h0;
      sb_q.push_back({4'h3, 16'h0});
      pressed[2] = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      check("clr_valid", key_valid, 1'b1);
      check("clr_code", key_code, 4'h3);
      check("clr_digits", digits, 16'h0);
      pressed[2] = 1'b0;
      wait_held(1'b0);
      repeat (2) @(negedge clk);

      // Reset while debouncing r2c2 aborts the press
      wait_row(4'b1011);
      pressed[10] = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      pressed = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_deb_rows", rows, 4'b1110);
      check("rst_deb_held", key_held, 1'b0);
      check("rst_deb_code", key_code, 4'h0);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      check("sb_empty", sb_q.size(), 0);
      check("pulse_count", n_pulse, 7);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
